audio_sample_scheduler: RTL and testbench

- Generates the audio sample-rate strobe in the clk_pixel domain using an exact fractional phase accumulator.
- Replaces the divided, gated audio clock with a clean one-cycle enable.
- Buffers stereo samples from a free-running source through a small FIFO, with valid/ready on the input side.
- Presents one stereo sample per strobe to the hdmi audio path; handles prefill and underrun.

---
 rtl/audio_sched_pkg.sv | 25 ++
 rtl/sample_fifo.sv | 67 ++++++
 rtl/audio_sample_scheduler.sv | 140 ++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// Shared types and helpers for the audio sample scheduler and its FIFO.
package audio_sched_pkg;

  // Scheduler modes: FILL waits for the FIFO to half-fill, RUN streams samples.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // Channel width for the packed stereo type. Blocks whose sample width differs
  // from this default carry stereo pairs as flat {left, right} vectors.
  localparam int SAMPLE_WIDTH = 16;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;

  // The accumulator needs one spare bit so that acc + increment cannot wrap
  // before it is compared against the modulus.
  function automatic int acc_width(input int modulus);
    return $clog2(modulus) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// DEPTH must be a power of two (at least 2) so that the pointers wrap naturally.
module sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       pop_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Audio sample scheduler: fractional phase accumulator producing a one-cycle
// sample strobe in the pixel clock domain, fed from a small stereo FIFO.
// Optional build macro AUDIO_SCHED_HOLD_LAST_EN: underrun and post-underrun
// FILL ticks repeat the last emitted sample instead of emitting silence.
module audio_sample_scheduler
  import audio_sched_pkg::*;
#(
  parameter int PIXEL_CLOCK_HZ  = 25200000,
  parameter int AUDIO_RATE      = 48000,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk_pixel_i,
  input  logic                          reset_i,
  input  logic                          src_valid_i,
  input  logic [AUDIO_BIT_WIDTH-1:0]    src_left_i,
  input  logic [AUDIO_BIT_WIDTH-1:0]    src_right_i,
  output logic                          src_ready_o,
  output logic                          sample_strobe_o,
  output logic [AUDIO_BIT_WIDTH-1:0]    sample_left_o,
  output logic [AUDIO_BIT_WIDTH-1:0]    sample_right_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o
);

  localparam int ACC_W  = acc_width(PIXEL_CLOCK_HZ);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PAIR_W = 2 * AUDIO_BIT_WIDTH;

  localparam logic [ACC_W-1:0] ACC_MOD       = ACC_W'(PIXEL_CLOCK_HZ);
  localparam logic [ACC_W-1:0] ACC_INC       = ACC_W'(AUDIO_RATE);
  localparam logic [LVL_W-1:0] PREFILL_LEVEL = LVL_W'(FIFO_DEPTH / 2);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic              tick;
  sched_state_t      state_q, state_d;
  logic              strobe_q;
  logic [PAIR_W-1:0] sample_q, sample_d;
  logic [PAIR_W-1:0] idle_sample;
  logic              underrun_q, underrun_set;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [PAIR_W-1:0] fifo_head;

  sample_fifo #(
    .DATA_WIDTH (PAIR_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_pixel_i),
    .reset_i (reset_i),
    .push_i  (src_valid_i && !fifo_full),
    .data_i  ({src_left_i, src_right_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

`ifdef AUDIO_SCHED_HOLD_LAST_EN
  // The output register is still zero until the first RUN pop, so holding it
  // gives silence before any real data and the last sample afterwards.
  assign idle_sample = sample_q;
`else
  assign idle_sample = '0;
`endif

  assign src_ready_o     = !fifo_full;
  assign sample_strobe_o = strobe_q;
  assign sample_left_o   = sample_q[PAIR_W-1:AUDIO_BIT_WIDTH];
  assign sample_right_o  = sample_q[AUDIO_BIT_WIDTH-1:0];
  assign fifo_level_o    = fifo_level;
  assign underrun_o      = underrun_q;

  // Phase accumulator: wraps modulo the pixel clock, so ticks never drift.
  always_comb begin
    acc_sum = acc_q + ACC_INC;
    acc_d   = acc_sum;
    tick    = 1'b0;
    if (acc_sum >= ACC_MOD) begin
      tick  = 1'b1;
      acc_d = acc_sum - ACC_MOD;
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) state_q <= FILL;
    else         state_q <= state_d;
  end

  // Enter RUN once half full (checked every cycle); fall back to FILL on an empty tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fifo_level >= PREFILL_LEVEL) state_d = RUN;
      RUN:     if (tick && fifo_empty) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Per-tick output selection: pop in RUN, otherwise emit the idle sample.
  always_comb begin
    fifo_pop     = 1'b0;
    underrun_set = 1'b0;
    sample_d     = sample_q;
    if (tick) begin
      case (state_q)
        RUN: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sample_d = fifo_head;
          end else begin
            underrun_set = 1'b1;
            sample_d     = idle_sample;
          end
        end
        default: sample_d = idle_sample;
      endcase
    end
  end

  // Registered accumulator, strobe, sample pair and sticky underrun flag.
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) begin
      acc_q      <= '0;
      strobe_q   <= 1'b0;
      sample_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      strobe_q   <= tick;
      sample_q   <= sample_d;
      underrun_q <= underrun_q | underrun_set;
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Testbench for audio_sample_scheduler: a small-ratio instance (10 / 3) for
// cadence, prefill, underrun, full-FIFO and reset behaviour, plus a default
// instance for the 525-cycle strobe spacing.
module tb_audio_sample_scheduler;

  typedef struct packed {
    int          cyc;
    logic [15:0] left;
    logic [15:0] right;
  } expEntry_t;

`ifdef AUDIO_SCHED_HOLD_LAST_EN
  localparam logic [15:0] IDLE_LEFT  = 16'd3;
  localparam logic [15:0] IDLE_RIGHT = 16'd4;
`else
  localparam logic [15:0] IDLE_LEFT  = 16'd0;
  localparam logic [15:0] IDLE_RIGHT = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic        srcValid;
  logic [15:0] srcLeft;
  logic [15:0] srcRight;
  logic        srcReady;
  logic        strobeA;
  logic [15:0] leftA;
  logic [15:0] rightA;
  logic [2:0]  levelA;
  logic        underrunA;

  logic        readyB;
  logic        strobeB;
  logic [15:0] leftB;
  logic [15:0] rightB;
  logic [2:0]  levelB;
  logic        underrunB;

  int          cyc;
  int          checks;
  int          errors;
  int          strobeCnt;
  int          bCount;
  int          bLast;
  logic        monEn;
  expEntry_t   expQ[$];

  audio_sample_scheduler #(
    .PIXEL_CLOCK_HZ  (10),
    .AUDIO_RATE      (3),
    .AUDIO_BIT_WIDTH (16),
    .FIFO_DEPTH      (4)
  ) dutA (
    .clk_pixel_i     (clk),
    .reset_i         (rst),
    .src_valid_i     (srcValid),
    .src_left_i      (srcLeft),
    .src_right_i     (srcRight),
    .src_ready_o     (srcReady),
    .sample_strobe_o (strobeA),
    .sample_left_o   (leftA),
    .sample_right_o  (rightA),
    .fifo_level_o    (levelA),
    .underrun_o      (underrunA)
  );

  audio_sample_scheduler dutB (
    .clk_pixel_i     (clk),
    .reset_i         (rst),
    .src_valid_i     (1'b0),
    .src_left_i      (16'd0),
    .src_right_i     (16'd0),
    .src_ready_o     (readyB),
    .sample_strobe_o (strobeB),
    .sample_left_o   (leftB),
    .sample_right_o  (rightB),
    .fifo_level_o    (levelB),
    .underrun_o      (underrunB)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number since the last reset release (first cycle after release is 1).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] l, input logic [15:0] r);
    srcValid = valid;
    srcLeft  = l;
    srcRight = r;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectStrobe(input int c, input logic [15:0] l, input logic [15:0] r);
    expEntry_t e;
    e.cyc   = c;
    e.left  = l;
    e.right = r;
    expQ.push_back(e);
  endtask

  // Scoreboard for the small instance: each strobe pops the next expected cycle and sample pair.
  always @(negedge clk) begin
    expEntry_t e;
    if (rst) begin
      strobeCnt = 0;
    end else if (strobeA) begin
      strobeCnt = strobeCnt + 1;
      if (monEn) begin
        checkOutput("strobe_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("strobe_cycle", cyc, e.cyc);
          checkOutput("sample_left", 32'(leftA), 32'(e.left));
          checkOutput("sample_right", 32'(rightA), 32'(e.right));
        end
      end
    end
  end

  // Default instance: first strobe at cycle 525, then exactly 525 cycles apart.
  always @(negedge clk) begin
    if (rst) begin
      bCount = 0;
      bLast  = 0;
    end else if (strobeB) begin
      if (bCount == 0) checkOutput("b_first_strobe_cycle", cyc, 525);
      else             checkOutput("b_strobe_spacing", cyc - bLast, 525);
      bLast  = cyc;
      bCount = bCount + 1;
    end
  end

  // Directed sequence for both instances.
  initial begin
    checks = 0;
    errors = 0;
    monEn  = 1'b0;
    rst    = 1'b1;
    applyStimulus(1'b0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_level", 32'(levelA), 32'd0);
    checkOutput("reset_strobe", 32'(strobeA), 32'd0);
    checkOutput("reset_left", 32'(leftA), 32'd0);
    checkOutput("reset_right", 32'(rightA), 32'd0);
    checkOutput("reset_underrun", 32'(underrunA), 32'd0);
    checkOutput("reset_ready", 32'(srcReady), 32'd1);

    expectStrobe(4, 16'd0, 16'd0);
    expectStrobe(7, 16'd0, 16'd0);
    expectStrobe(10, 16'd1, 16'd2);
    expectStrobe(14, 16'd3, 16'd4);
    expectStrobe(17, IDLE_LEFT, IDLE_RIGHT);
    expectStrobe(20, IDLE_LEFT, IDLE_RIGHT);
    expectStrobe(24, 16'd11, 16'd12);
    expectStrobe(27, 16'd13, 16'd14);
    monEn = 1'b1;
    rst   = 1'b0;

    stepTo(4);  applyStimulus(1'b1, 16'd1, 16'd2);
    stepTo(5);  applyStimulus(1'b1, 16'd3, 16'd4);
    stepTo(6);  applyStimulus(1'b0, 16'd0, 16'd0);
    checkOutput("prefill_level", 32'(levelA), 32'd2);

    stepTo(16);
    checkOutput("underrun_before", 32'(underrunA), 32'd0);
    checkOutput("drained_level", 32'(levelA), 32'd0);
    stepTo(17);
    checkOutput("underrun_set", 32'(underrunA), 32'd1);
    applyStimulus(1'b1, 16'd11, 16'd12);
    stepTo(18); applyStimulus(1'b1, 16'd13, 16'd14);
    stepTo(19); applyStimulus(1'b1, 16'd15, 16'd16);
    stepTo(20); applyStimulus(1'b1, 16'd17, 16'd18);
    stepTo(21);
    checkOutput("full_level", 32'(levelA), 32'd4);
    checkOutput("full_ready", 32'(srcReady), 32'd0);
    applyStimulus(1'b1, 16'd19, 16'd20);
    stepTo(24);
    checkOutput("pop_refused_push_level", 32'(levelA), 32'd3);
    checkOutput("ready_after_pop", 32'(srcReady), 32'd1);
    stepTo(25);
    checkOutput("push_after_pop_level", 32'(levelA), 32'd4);
    applyStimulus(1'b0, 16'd0, 16'd0);
    stepTo(28);
    checkOutput("midrun_level", 32'(levelA), 32'd3);
    checkOutput("underrun_sticky", 32'(underrunA), 32'd1);
    checkOutput("phase1_all_strobes_seen", 32'(expQ.size()), 32'd0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun_reset_level", 32'(levelA), 32'd0);
    checkOutput("midrun_reset_left", 32'(leftA), 32'd0);
    checkOutput("midrun_reset_right", 32'(rightA), 32'd0);
    checkOutput("midrun_reset_underrun", 32'(underrunA), 32'd0);
    checkOutput("midrun_reset_strobe", 32'(strobeA), 32'd0);
    checkOutput("midrun_reset_ready", 32'(srcReady), 32'd1);
    expQ.delete();
    expectStrobe(4, 16'd0, 16'd0);
    expectStrobe(7, 16'd0, 16'd0);
    expectStrobe(10, 16'd0, 16'd0);
    rst = 1'b0;

    stepTo(10);
    @(negedge clk);
    #1;
    checkOutput("restart_strobes_seen", 32'(expQ.size()), 32'd0);
    monEn = 1'b0;

    stepTo(10000);
    @(negedge clk);
    #1;
    checkOutput("strobes_in_10000_cycles", strobeCnt, 3000);

    while (bCount < 101 && cyc < 60000) begin
      @(posedge clk);
      #1;
    end
    checkOutput("b_strobe_total", 32'(bCount >= 101), 32'd1);
    checkOutput("b_underrun", 32'(underrunB), 32'd0);
    checkOutput("b_level", 32'(levelB), 32'd0);
    checkOutput("b_ready", 32'(readyB), 32'd1);
    checkOutput("b_left", 32'(leftB), 32'd0);
    checkOutput("b_right", 32'(rightB), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
